// File: rtl/posit_decoder_iter.sv
// posit_decoder_iter: multi-cycle posit decoder.
// Walks the regime run one bit per cycle, then registers sign, regime k,
// exponent and fraction together with the zero/NaR flags.
// Optional build macro: POSIT_DEC_SPECIAL_BYPASS_EN. When it is defined, 0 and NaR
// skip the scan and go straight to DONE.
module posit_decoder_iter #(
   parameter int N         = 16,
   parameter int ES        = 1,
   parameter int K_BITS    = $clog2(N) + 1,
   parameter int MANT_SIZE = ((N - 3 - ES) > 0) ? (N - 3 - ES) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [N-1:0]         posit_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 is_zero_o,
   output logic                 is_nar_o,
   output logic                 sign_o,
   output logic [K_BITS-1:0]    k_o,
   output logic [ES-1:0]        exp_o,
   output logic [MANT_SIZE-1:0] frac_o
);

   localparam int IW = $clog2(N);
   localparam int MW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q, state_d;
   logic            sign_q, sign_d;
   logic [N-1:0]    abs_q, abs_d;
   logic            r0_q, r0_d;
   logic [MW-1:0]   m_q, m_d;
   logic [IW-1:0]   idx_q, idx_d;

   logic                 load_out;
   logic                 zero_d, nar_d, osign_d;
   logic [K_BITS-1:0]    k_d;
   logic [ES-1:0]        exp_d;
   logic [MANT_SIZE-1:0] frac_d;

   logic                 is_zero_q, is_nar_q, osign_q;
   logic [K_BITS-1:0]    k_q;
   logic [ES-1:0]        exp_q;
   logic [MANT_SIZE-1:0] frac_q;

   int              reg_len;
   int              frac_len;
   logic [N-1:0]    mask_v;

   // Scan state and operand registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         abs_q   <= '0;
         r0_q    <= 1'b0;
         m_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         abs_q   <= abs_d;
         r0_q    <= r0_d;
         m_q     <= m_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic and field extraction from the final run length
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      abs_d    = abs_q;
      r0_d     = r0_q;
      m_d      = m_q;
      idx_d    = idx_q;
      load_out = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               sign_d  = posit_i[N-1];
               abs_d   = posit_i[N-1] ? (~posit_i + {{(N-1){1'b0}}, 1'b1}) : posit_i;
               r0_d    = abs_d[N-2];
               m_d     = MW'(1);
               idx_d   = IW'(N - 3);
               state_d = SCAN;
`ifdef POSIT_DEC_SPECIAL_BYPASS_EN
               if (posit_i[N-2:0] == '0) begin
                  state_d  = DONE;
                  load_out = 1'b1;
               end
`endif
            end
         end
         SCAN: begin
            if (abs_q[idx_q] == r0_q) begin
               m_d = m_q + MW'(1);
               if (idx_q == '0) begin
                  state_d  = DONE;
                  load_out = 1'b1;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end else begin
               state_d  = DONE;
               load_out = 1'b1;
            end
         end
         DONE: begin
            if (ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Regime covers the run plus its terminator, clipped at the LSB.
      reg_len  = (int'(m_d) + 1 > N - 1) ? (N - 1) : (int'(m_d) + 1);
      frac_len = N - 1 - reg_len - ES;
      mask_v   = (frac_len > 0) ? ({N{1'b1}} >> (N - frac_len)) : '0;

      zero_d  = (abs_d == '0) && !sign_d;
      nar_d   = sign_d && (abs_d == {1'b1, {(N-1){1'b0}}});
      osign_d = sign_d;
      k_d     = r0_d ? (K_BITS'(m_d) - K_BITS'(1)) : (K_BITS'(0) - K_BITS'(m_d));
      // Shifting the sign and regime out leaves the exponent at the top,
      // zero-filled when it was truncated.
      exp_d   = ES'((abs_d << (reg_len + 1)) >> (N - ES));
      frac_d  = MANT_SIZE'(abs_d & mask_v);

      if (zero_d || nar_d) begin
         k_d    = '0;
         exp_d  = '0;
         frac_d = '0;
      end
   end

   // Result registers, updated only on entry to DONE
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         is_zero_q <= 1'b0;
         is_nar_q  <= 1'b0;
         osign_q   <= 1'b0;
         k_q       <= '0;
         exp_q     <= '0;
         frac_q    <= '0;
      end else if (load_out) begin
         is_zero_q <= zero_d;
         is_nar_q  <= nar_d;
         osign_q   <= osign_d;
         k_q       <= k_d;
         exp_q     <= exp_d;
         frac_q    <= frac_d;
      end
   end

   assign ready_o   = (state_q == IDLE);
   assign valid_o   = (state_q == DONE);
   assign is_zero_o = is_zero_q;
   assign is_nar_o  = is_nar_q;
   assign sign_o    = osign_q;
   assign k_o       = k_q;
   assign exp_o     = exp_q;
   assign frac_o    = frac_q;

endmodule

// File: tb/tb_posit_decoder_iter.sv
// Directed testbench for posit_decoder_iter, N=16, ES=1.
module tb_posit_decoder_iter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [15:0] posit_i;
   logic        valid_o;
   logic        ready_i;
   logic        is_zero_o;
   logic        is_nar_o;
   logic        sign_o;
   logic [4:0]  k_o;
   logic [0:0]  exp_o;
   logic [11:0] frac_o;

   int n_cmp = 0;
   int n_err = 0;

`ifdef POSIT_DEC_SPECIAL_BYPASS_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 15;
`endif

   posit_decoder_iter #(.N(16), .ES(1)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .posit_i   (posit_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .is_zero_o (is_zero_o),
      .is_nar_o  (is_nar_o),
      .sign_o    (sign_o),
      .k_o       (k_o),
      .exp_o     (exp_o),
      .frac_o    (frac_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts edges from the accept edge (1) until valid_o is seen.
   task automatic wait_valid(output int cnt);
      cnt = 1;
      while (!valid_o && cnt < 40) begin
         @(posedge clk_i); #1;
         cnt++;
      end
   endtask

   task automatic check_fields(input string tag, input logic zf, input logic nf, input logic sg,
                               input int k, input logic [0:0] e, input logic [11:0] f);
      check_val({tag, " zero"}, 32'(is_zero_o), 32'(zf));
      check_val({tag, " nar"},  32'(is_nar_o),  32'(nf));
      check_val({tag, " sign"}, 32'(sign_o),    32'(sg));
      check_val({tag, " k"},    32'(int'($signed(k_o))), 32'(k));
      check_val({tag, " exp"},  32'(exp_o),     32'(e));
      check_val({tag, " frac"}, 32'(frac_o),    32'(f));
   endtask

   // Entered and left at posedge+1 with the DUT idle and ready_i high.
   task automatic run_vec(input string tag, input logic [15:0] p, input int lat,
                          input logic zf, input logic nf, input logic sg,
                          input int k, input logic [0:0] e, input logic [11:0] f);
      int cnt;
      check_val({tag, " ready"}, 32'(ready_o), 32'd1);
      valid_i = 1'b1;
      posit_i = p;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      wait_valid(cnt);
      check_val({tag, " latency"}, 32'(cnt), 32'(lat));
      check_fields(tag, zf, nf, sg, k, e, f);
      $display("vec %s posit=%h lat=%0d sign=%0d k=%0d exp=%0d frac=%h z=%0d nar=%0d",
               tag, p, cnt, sign_o, $signed(k_o), exp_o, frac_o, is_zero_o, is_nar_o);
      @(posedge clk_i); #1;
      check_val({tag, " back idle"}, 32'(valid_o), 32'd0);
   endtask

   initial begin
      int cnt;
      int vhits;
      rst_i   = 1'b1;
      valid_i = 1'b0;
      posit_i = '0;
      ready_i = 1'b1;
      #12;
      check_val("rst ready",  32'(ready_o), 32'd1);
      check_val("rst valid",  32'(valid_o), 32'd0);
      check_fields("rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 12'h000);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      run_vec("6C00", 16'h6C00, 3,  1'b0, 1'b0, 1'b0,   1, 1'b1, 12'h400);
      run_vec("B000", 16'hB000, 2,  1'b0, 1'b0, 1'b1,   0, 1'b1, 12'h000);
      run_vec("0001", 16'h0001, 15, 1'b0, 1'b0, 1'b0, -14, 1'b0, 12'h000);
      run_vec("2A5B", 16'h2A5B, 2,  1'b0, 1'b0, 1'b0,  -1, 1'b0, 12'hA5B);
      run_vec("FFFF", 16'hFFFF, 15, 1'b0, 1'b0, 1'b1, -14, 1'b0, 12'h000);
      run_vec("0000", 16'h0000, SPEC_LAT, 1'b1, 1'b0, 1'b0, 0, 1'b0, 12'h000);
      run_vec("8000", 16'h8000, SPEC_LAT, 1'b0, 1'b1, 1'b1, 0, 1'b0, 12'h000);
      run_vec("7FFF", 16'h7FFF, 15, 1'b0, 1'b0, 1'b0,  14, 1'b0, 12'h000);

      // Reset in the middle of a scan, with non-zero results still held.
      valid_i = 1'b1;
      posit_i = 16'h0001;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (5) begin @(posedge clk_i); #1; end
      check_val("mid scan busy", 32'(ready_o), 32'd0);
      #2 rst_i = 1'b1;
      #1;
      check_val("async rst ready", 32'(ready_o), 32'd1);
      check_val("async rst valid", 32'(valid_o), 32'd0);
      check_fields("async rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 12'h000);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      vhits = 0;
      repeat (20) begin
         @(posedge clk_i); #1;
         if (valid_o) vhits++;
      end
      check_val("no valid after rst", 32'(vhits), 32'd0);
      $display("vec reset-mid-scan valid_pulses=%0d", vhits);
      run_vec("6C00 post rst", 16'h6C00, 3, 1'b0, 1'b0, 1'b0, 1, 1'b1, 12'h400);

      // Backpressure: result held while a second posit waits on valid_i.
      ready_i = 1'b0;
      valid_i = 1'b1;
      posit_i = 16'h6C00;
      @(posedge clk_i); #1;
      posit_i = 16'hB000;
      wait_valid(cnt);
      check_val("bp latency", 32'(cnt), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_val("bp valid held", 32'(valid_o), 32'd1);
         check_val("bp ready low",  32'(ready_o), 32'd0);
         check_fields("bp hold", 1'b0, 1'b0, 1'b0, 1, 1'b1, 12'h400);
         @(posedge clk_i); #1;
      end
      check_val("bp valid 4th", 32'(valid_o), 32'd1);
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      check_val("bp idle ready", 32'(ready_o), 32'd1);
      check_val("bp idle valid", 32'(valid_o), 32'd0);
      check_fields("bp still first", 1'b0, 1'b0, 1'b0, 1, 1'b1, 12'h400);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      wait_valid(cnt);
      check_val("bp second latency", 32'(cnt), 32'd2);
      check_fields("bp second", 1'b0, 1'b0, 1'b1, 0, 1'b1, 12'h000);
      $display("vec backpressure second=B000 lat=%0d k=%0d", cnt, $signed(k_o));
      @(posedge clk_i); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
